aes128_enc_core: RTL

- Iterative AES-128 encryption datapath that consumes the 1408-bit expanded key schedule produced by the key-expansion stage.
- Processes one 128-bit block at a time, executing one cipher round per clock: initial AddRoundKey, then rounds 1..10.
- Valid/ready handshakes on both sides.
- Sits directly downstream of key expansion and upstream of the output/ciphertext buffer.

---
 rtl/aes128_enc_core.sv | 136 +++++++++++++
 1 files changed

// File: rtl/aes128_enc_core.sv
// Iterative AES-128 encryption core: one round per clock, valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready/plaintext/round_keys in; out_valid/out_ready/ciphertext/busy out.
module aes128_enc_core #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          plaintext,
  input  logic [128*(NR+1)-1:0] round_keys,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          ciphertext,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       st;
  logic [3:0]   rnd;
  logic [127:0] state_reg;
  logic [127:0] rk;
  logic [127:0] round_out;
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];

  // Entry 0 sits in the top byte of SBOX.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign in_ready   = (st == IDLE);
  assign busy       = (st != IDLE);
  assign ciphertext = state_reg;
  assign rk         = round_keys[{rnd, 7'b0} +: 128];

  // Byte i lives at row i%4, column i/4.
  always_comb begin
    for (int i = 0; i < 16; i++)
      sb[i] = sbox(state_reg[127-8*i -: 8]);
  end

  always_comb begin
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[r+4*c] = sb[r+4*((c+r)%4)];
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1]
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2])
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2])
                ^ xt(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1]
                ^ sr[4*c+2] ^ xt(sr[4*c+3]);
    end
  end

  // Final round skips MixColumns.
  always_comb begin
    round_out = '0;
    for (int i = 0; i < 16; i++)
      round_out[127-8*i -: 8] = ((rnd == LAST) ? sr[i] : mc[i])
                              ^ rk[127-8*i -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      rnd       <= '0;
      state_reg <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            state_reg <= plaintext ^ round_keys[127:0];
            rnd       <= 4'd1;
            st        <= RUN;
          end
        end
        RUN: begin
          state_reg <= round_out;
          if (rnd == LAST) begin
            st        <= DONE;
            out_valid <= 1'b1;
          end else if (rnd != 4'hf) begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
